// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bus.
// The pipeline datapath drives the hazard/branch/memory status (master), and the
// controller returns register enables, flushes and its status counters (slave).
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        idex_mem_read;
  logic [4:0]  idex_reg_dest;
  logic        ex_branch_taken;
  logic        ex_jump;
  logic        mem_busy;
  logic        pc_enable;
  logic        ifid_enable;
  logic        idex_enable;
  logic        ifid_flush;
  logic        idex_flush;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, idex_mem_read, idex_reg_dest,
           ex_branch_taken, ex_jump, mem_busy,
    input  pc_enable, ifid_enable, idex_enable, ifid_flush, idex_flush,
           mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, idex_mem_read, idex_reg_dest,
           ex_branch_taken, ex_jump, mem_busy,
    output pc_enable, ifid_enable, idex_enable, ifid_flush, idex_flush,
           mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the PC, IF/ID and ID/EX pipeline registers.
// Inserts load-use bubbles, squashes on taken branches/jumps, freezes the whole
// pipe while data memory is busy, and keeps stall/flush/timeout status.
module pipeline_hazard_ctrl #(
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input logic                  clock,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

  localparam logic [2:0]  INIT_BUBBLES  = 3'(LOAD_BUBBLES - 1);
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(MEM_TIMEOUT);

  state_t      state;
  logic [2:0]  bubbleCnt;
  logic [15:0] waitCnt;
  logic        retLoad;
  logic        memTimeout;
  logic [31:0] stallCycles;
  logic [15:0] flushCount;

  logic        loadUseHazard;
  logic        squash;
  logic        evalLoadStall;
  logic [15:0] nextWait;
  logic        pcEnable;
  logic        ifidEnable;
  logic        idexEnable;
  logic        ifidFlush;
  logic        idexFlush;

  // Hazard detection; a freeze that has just ended is evaluated as the state it interrupted
  always_comb begin
    loadUseHazard = bus.idex_mem_read && (bus.idex_reg_dest != 5'd0) &&
                    ((bus.idex_reg_dest == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.idex_reg_dest == bus.id_rt)));
    squash        = bus.ex_branch_taken || bus.ex_jump;
    evalLoadStall = (state == LOAD_STALL) || ((state == MEM_WAIT) && retLoad);
    nextWait      = (waitCnt == 16'hFFFF) ? waitCnt : waitCnt + 16'd1;
  end

  // Same-cycle enable/flush decisions: reset, then freeze, squash, bubble, run
  always_comb begin
    pcEnable   = 1'b1;
    ifidEnable = 1'b1;
    idexEnable = 1'b1;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    if (reset) begin
      pcEnable   = 1'b0;
      ifidEnable = 1'b0;
      idexEnable = 1'b0;
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
    end else if (bus.mem_busy) begin
      pcEnable   = 1'b0;
      ifidEnable = 1'b0;
      idexEnable = 1'b0;
    end else if (squash) begin
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
    end else if (evalLoadStall || loadUseHazard) begin
      pcEnable   = 1'b0;
      ifidEnable = 1'b0;
      idexFlush  = 1'b1;
    end
  end

  // Controller state, bubble/wait counters and saturating status counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      bubbleCnt   <= '0;
      waitCnt     <= '0;
      retLoad     <= 1'b0;
      memTimeout  <= 1'b0;
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (!pcEnable && (stallCycles != 32'hFFFFFFFF)) begin
        stallCycles <= stallCycles + 32'd1;
      end
      if (bus.mem_busy) begin
        state   <= MEM_WAIT;
        waitCnt <= nextWait;
        if (state != MEM_WAIT) begin
          retLoad <= (state == LOAD_STALL);
        end
        if (nextWait >= TIMEOUT_LIMIT) begin
          memTimeout <= 1'b1;
        end
      end else begin
        waitCnt <= '0;
        if (squash) begin
          if (flushCount != 16'hFFFF) begin
            flushCount <= flushCount + 16'd1;
          end
          bubbleCnt <= '0;
          state     <= RUN;
        end else if (evalLoadStall) begin
          bubbleCnt <= bubbleCnt - 3'd1;
          state     <= (bubbleCnt == 3'd1) ? RUN : LOAD_STALL;
        end else if (loadUseHazard && (LOAD_BUBBLES > 1)) begin
          bubbleCnt <= INIT_BUBBLES;
          state     <= LOAD_STALL;
        end else begin
          state <= RUN;
        end
      end
    end
  end

  assign bus.pc_enable    = pcEnable;
  assign bus.ifid_enable  = ifidEnable;
  assign bus.idex_enable  = idexEnable;
  assign bus.ifid_flush   = ifidFlush;
  assign bus.idex_flush   = idexFlush;
  assign bus.mem_timeout  = memTimeout;
  assign bus.stall_cycles = stallCycles;
  assign bus.flush_count  = flushCount;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
// Two instances (LOAD_BUBBLES=1/MEM_TIMEOUT=255 and LOAD_BUBBLES=3/MEM_TIMEOUT=3)
// see identical stimulus; a bubbles-remaining reference model checks every cycle.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       memRead;
    logic [4:0] dest;
    logic       taken;
    logic       jump;
    logic       busy;
    logic       rst;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [4:0] expA;
    logic [4:0] expB;
  } vec_t;

  // Control word packing: {pc_enable, ifid_enable, idex_enable, ifid_flush, idex_flush}
  localparam logic [4:0] CTL_RUN = 5'b11100;
  localparam logic [4:0] CTL_BUB = 5'b00101;
  localparam logic [4:0] CTL_SQ  = 5'b11111;
  localparam logic [4:0] CTL_FRZ = 5'b00000;
  localparam logic [4:0] CTL_RST = 5'b00011;

  logic clock = 1'b0;
  logic reset;

  pipeline_hazard_ctrl_if ifA ();
  pipeline_hazard_ctrl_if ifB ();

  pipeline_hazard_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(255)) dutA (
    .clock(clock), .reset(reset), .bus(ifA)
  );
  pipeline_hazard_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(3)) dutB (
    .clock(clock), .reset(reset), .bus(ifB)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  always #5 clock = ~clock;

  int          vecCount = 0;
  int          missCount = 0;
  logic [4:0]  actA;
  logic [4:0]  actB;

  int          bubblesLeft [2];
  int          waitRun [2];
  logic        tOut [2];
  logic [31:0] stallCnt [2];
  logic [15:0] flushCnt [2];
  int          lbOf [2];
  int          mtOf [2];

  vec_t        tbl [18];

  function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt,
                               input logic usesRt, input logic memRead,
                               input logic [4:0] dest, input logic taken,
                               input logic jump, input logic busy, input logic rst);
    stim_t s;
    s.rs = rs; s.rt = rt; s.usesRt = usesRt; s.memRead = memRead; s.dest = dest;
    s.taken = taken; s.jump = jump; s.busy = busy; s.rst = rst;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a count of bubbles still owed, a busy-run length, and counters
  task automatic modelStep(input int i, input stim_t s, output logic [4:0] ctl);
    logic hz;
    hz = s.memRead && (s.dest != 5'd0) &&
         ((s.dest == s.rs) || (s.usesRt && (s.dest == s.rt)));
    ctl = CTL_RUN;
    if (s.rst) begin
      ctl = CTL_RST;
      bubblesLeft[i] = 0; waitRun[i] = 0; tOut[i] = 1'b0;
      stallCnt[i] = '0; flushCnt[i] = '0;
    end else begin
      if (s.busy) begin
        ctl = CTL_FRZ;
        if (waitRun[i] < 65535) waitRun[i]++;
        if (waitRun[i] >= mtOf[i]) tOut[i] = 1'b1;
      end else begin
        waitRun[i] = 0;
        if (s.taken || s.jump) begin
          ctl = CTL_SQ;
          bubblesLeft[i] = 0;
          if (flushCnt[i] != 16'hFFFF) flushCnt[i]++;
        end else if (bubblesLeft[i] > 0) begin
          ctl = CTL_BUB;
          bubblesLeft[i]--;
        end else if (hz) begin
          ctl = CTL_BUB;
          bubblesLeft[i] = lbOf[i] - 1;
        end
      end
      if (!ctl[4] && (stallCnt[i] != 32'hFFFFFFFF)) stallCnt[i]++;
    end
  endtask

  // Drive one cycle at posedge+1, check controls mid-cycle, check registers after the edge
  task automatic applyStimulus(input stim_t s);
    logic [4:0] expCtl;
    reset = s.rst;
    ifA.id_rs = s.rs; ifA.id_rt = s.rt; ifA.id_uses_rt = s.usesRt;
    ifA.idex_mem_read = s.memRead; ifA.idex_reg_dest = s.dest;
    ifA.ex_branch_taken = s.taken; ifA.ex_jump = s.jump; ifA.mem_busy = s.busy;
    ifB.id_rs = s.rs; ifB.id_rt = s.rt; ifB.id_uses_rt = s.usesRt;
    ifB.idex_mem_read = s.memRead; ifB.idex_reg_dest = s.dest;
    ifB.ex_branch_taken = s.taken; ifB.ex_jump = s.jump; ifB.mem_busy = s.busy;
    #4;
    actA = {ifA.pc_enable, ifA.ifid_enable, ifA.idex_enable, ifA.ifid_flush, ifA.idex_flush};
    actB = {ifB.pc_enable, ifB.ifid_enable, ifB.idex_enable, ifB.ifid_flush, ifB.idex_flush};
    modelStep(0, s, expCtl);
    checkOutput("ctlA", 32'(actA), 32'(expCtl));
    modelStep(1, s, expCtl);
    checkOutput("ctlB", 32'(actB), 32'(expCtl));
    @(posedge clock);
    #1;
    checkOutput("stallA", ifA.stall_cycles, stallCnt[0]);
    checkOutput("flushA", 32'(ifA.flush_count), 32'(flushCnt[0]));
    checkOutput("timeoutA", 32'(ifA.mem_timeout), 32'(tOut[0]));
    checkOutput("stallB", ifB.stall_cycles, stallCnt[1]);
    checkOutput("flushB", 32'(ifB.flush_count), 32'(flushCnt[1]));
    checkOutput("timeoutB", 32'(ifB.mem_timeout), 32'(tOut[1]));
  endtask

  task automatic setVec(input int idx, input stim_t s, input logic [4:0] a, input logic [4:0] b);
    tbl[idx].s = s;
    tbl[idx].expA = a;
    tbl[idx].expB = b;
  endtask

  // Test sequence: table, hand-written corner cases, then randomized traffic
  initial begin
    stim_t idle, rstV, busyV, hzRs, s;
    int    busyLeft;
    idle  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rstV  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    busyV = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    hzRs  = mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    lbOf[0] = 1; mtOf[0] = 255;
    lbOf[1] = 3; mtOf[1] = 3;
    for (int i = 0; i < 2; i++) begin
      bubblesLeft[i] = 0; waitRun[i] = 0; tOut[i] = 1'b0;
      stallCnt[i] = '0; flushCnt[i] = '0;
    end

    setVec(0,  rstV, CTL_RST, CTL_RST);
    setVec(1,  idle, CTL_RUN, CTL_RUN);
    setVec(2,  hzRs, CTL_BUB, CTL_BUB);
    setVec(3,  idle, CTL_RUN, CTL_BUB);
    setVec(4,  idle, CTL_RUN, CTL_BUB);
    setVec(5,  idle, CTL_RUN, CTL_RUN);
    setVec(6,  mk(5'd0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), CTL_BUB, CTL_BUB);
    setVec(7,  idle, CTL_RUN, CTL_BUB);
    setVec(8,  idle, CTL_RUN, CTL_BUB);
    setVec(9,  mk(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), CTL_RUN, CTL_RUN);
    setVec(10, mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), CTL_RUN, CTL_RUN);
    setVec(11, mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0), CTL_SQ,  CTL_SQ);
    setVec(12, idle, CTL_RUN, CTL_RUN);
    setVec(13, hzRs, CTL_BUB, CTL_BUB);
    setVec(14, mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), CTL_SQ, CTL_SQ);
    setVec(15, idle, CTL_RUN, CTL_RUN);
    setVec(16, busyV, CTL_FRZ, CTL_FRZ);
    setVec(17, idle, CTL_RUN, CTL_RUN);

    reset = 1'b1;
    ifA.id_rs = '0; ifA.id_rt = '0; ifA.id_uses_rt = 1'b0; ifA.idex_mem_read = 1'b0;
    ifA.idex_reg_dest = '0; ifA.ex_branch_taken = 1'b0; ifA.ex_jump = 1'b0; ifA.mem_busy = 1'b0;
    ifB.id_rs = '0; ifB.id_rt = '0; ifB.id_uses_rt = 1'b0; ifB.idex_mem_read = 1'b0;
    ifB.idex_reg_dest = '0; ifB.ex_branch_taken = 1'b0; ifB.ex_jump = 1'b0; ifB.mem_busy = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].s);
      checkOutput($sformatf("tblA[%0d]", i), 32'(actA), 32'(tbl[i].expA));
      checkOutput($sformatf("tblB[%0d]", i), 32'(actB), 32'(tbl[i].expB));
    end

    $display("[TB] squash beats load-use");
    applyStimulus(rstV);
    applyStimulus(mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0));
    checkOutput("sqCtlB", 32'(actB), 32'(CTL_SQ));
    checkOutput("sqFlushA", 32'(ifA.flush_count), 32'd1);
    checkOutput("sqFlushB", 32'(ifB.flush_count), 32'd1);
    checkOutput("sqStallB", ifB.stall_cycles, 32'd0);

    $display("[TB] freeze during second bubble");
    applyStimulus(rstV);
    applyStimulus(hzRs);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(busyV);
      checkOutput($sformatf("frzCtlB%0d", k), 32'(actB), 32'(CTL_FRZ));
    end
    applyStimulus(idle);
    checkOutput("postFrzBub1", 32'(actB), 32'(CTL_BUB));
    applyStimulus(idle);
    checkOutput("postFrzBub2", 32'(actB), 32'(CTL_BUB));
    applyStimulus(idle);
    checkOutput("postFrzRun", 32'(actB), 32'(CTL_RUN));
    checkOutput("frzStallB", ifB.stall_cycles, 32'd7);
    checkOutput("frzStallA", ifA.stall_cycles, 32'd5);

    $display("[TB] memory timeout");
    applyStimulus(rstV);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(busyV);
      checkOutput($sformatf("toutB_busy%0d", k), 32'(ifB.mem_timeout), 32'(k >= 3));
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(idle);
      checkOutput($sformatf("toutB_sticky%0d", k), 32'(ifB.mem_timeout), 32'd1);
      checkOutput($sformatf("toutA_idle%0d", k), 32'(ifA.mem_timeout), 32'd0);
    end
    applyStimulus(rstV);
    checkOutput("toutB_cleared", 32'(ifB.mem_timeout), 32'd0);

    $display("[TB] reset in load stall");
    applyStimulus(hzRs);
    applyStimulus(idle);
    applyStimulus(rstV);
    checkOutput("rstCtlB", 32'(actB), 32'(CTL_RST));
    checkOutput("rstStallB", ifB.stall_cycles, 32'd0);
    checkOutput("rstFlushB", 32'(ifB.flush_count), 32'd0);
    applyStimulus(idle);
    checkOutput("rstRunB", 32'(actB), 32'(CTL_RUN));
    checkOutput("rstStallAfterB", ifB.stall_cycles, 32'd0);

    $display("[TB] randomized traffic");
    applyStimulus(rstV);
    busyLeft = 0;
    for (int n = 0; n < 3000; n++) begin
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.usesRt  = 1'($urandom_range(0, 1));
      s.memRead = ($urandom_range(0, 2) != 0);
      s.dest    = 5'($urandom_range(0, 3));
      s.taken   = ($urandom_range(0, 11) == 0);
      s.jump    = ($urandom_range(0, 15) == 0);
      s.rst     = ($urandom_range(0, 199) == 0);
      if (busyLeft > 0) begin
        s.busy = 1'b1;
        busyLeft--;
      end else if ($urandom_range(0, 9) == 0) begin
        s.busy = 1'b1;
        busyLeft = int'($urandom_range(0, 5));
      end else begin
        s.busy = 1'b0;
      end
      applyStimulus(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller that drives the enable and flush inputs of the PC, IF/ID and ID/EX pipeline registers. It sits beside the ID/EX register, watching the instruction entering ID/EX and the instruction held in ID/EX. From that it decides when the register captures, holds, or receives a bubble. It also provides the following:
- load-use stalls of configurable length;
- branch/jump squash;
- a full-pipe freeze while data memory is busy;
- a memory-timeout flag;
- stall and flush performance counters.

## Interface
Parameters:
- LOAD_BUBBLES, 1: bubbles inserted per load-use hazard (1..7).
- MEM_TIMEOUT, 255: mem_busy cycles tolerated before mem_timeout sets (1..65535).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt as a source.
- idex_mem_read  in  1  the ID/EX-held instruction is a load.
- idex_reg_dest  in  5  destination register of the ID/EX-held instruction.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- ex_jump  in  1  jump in EX this cycle.
- mem_busy  in  1  data memory not ready; the pipe must freeze.
- pc_enable  out  1  PC load enable.
- ifid_enable  out  1  IF/ID enable.
- idex_enable  out  1  ID/EX enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX control fields are zeroed (bubble).
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  32  saturating count of cycles with pc_enable=0.
- flush_count  out  16  saturating count of branch/jump squashes.

## Operation
- The state register is one of RUN, LOAD_STALL, MEM_WAIT. The support registers are:
  - bubble_cnt (3 bits);
  - wait_cnt (16 bits);
  - ret_load (1 bit): return target for MEM_WAIT.
- Control outputs are combinational from the current state and the inputs. All other outputs are registered.
- Load-use hazard (hz): idex_mem_read AND idex_reg_dest≠0 AND (idex_reg_dest==id_rs OR (id_uses_rt AND idex_reg_dest==id_rt)).
- Priority within any state: mem_busy > (ex_branch_taken OR ex_jump) > hz.
- Freeze action (any state with mem_busy=1):
  - all enables 0, both flushes 0;
  - next state MEM_WAIT;
  - on entry from RUN or LOAD_STALL, ret_load is captured as (state==LOAD_STALL).
- Squash action:
  - all enables 1, ifid_flush=1, idex_flush=1;
  - flush_count increments;
  - bubble_cnt clears;
  - next state RUN.
- Bubble action:
  - pc_enable=0, ifid_enable=0, idex_enable=1, idex_flush=1, ifid_flush=0.
- RUN:
  - freeze / squash per priority;
  - hz: bubble action. If LOAD_BUBBLES>1, bubble_cnt←LOAD_BUBBLES-1 and go to LOAD_STALL; otherwise stay in RUN.
  - otherwise: all enables 1, no flush.
- LOAD_STALL:
  - freeze / squash per priority;
  - otherwise bubble action and bubble_cnt decrements. At bubble_cnt==1 the next state is RUN.
- MEM_WAIT:
  - while mem_busy=1: freeze, and wait_cnt increments (saturating at 65535);
  - when wait_cnt reaches MEM_TIMEOUT, mem_timeout←1 (sticky until reset);
  - when mem_busy=0: wait_cnt←0. The current cycle is evaluated as RUN (ret_load=0) or LOAD_STALL (ret_load=1), including squash/hz/bubble outputs.
- stall_cycles increments on every cycle with pc_enable=0, holding at 0xFFFFFFFF. flush_count holds at 0xFFFF.
- Reset (synchronous, overrides everything):
  - state←RUN; bubble_cnt, wait_cnt, ret_load, mem_timeout, stall_cycles, flush_count ←0;
  - while reset=1: pc_enable=ifid_enable=idex_enable=0, ifid_flush=idex_flush=1.
  - Reset asserted mid-stall or mid-wait abandons that state immediately.

## Timing
- Zero-cycle response: enables and flushes reflect the inputs within the same cycle, for capture at the next posedge.
- A load-use hazard costs exactly LOAD_BUBBLES cycles of pc_enable=0, in the absence of mem_busy.
- A squash costs one cycle with two bubbles; there is no stall.
- Freeze lasts exactly as many cycles as mem_busy is high; bubble_cnt is preserved across it.
- mem_timeout rises on the posedge ending the MEM_TIMEOUT-th consecutive busy cycle.
- The first cycle after reset deassertion is RUN, with all enables 1 if there is no hazard.

## Test plan
- Load-use, LOAD_BUBBLES=1: idex_mem_read=1, idex_reg_dest=5, id_rs=5 for one cycle -> pc_enable=0, idex_flush=1 for 1 cycle; stall_cycles=1.
- LOAD_BUBBLES=3, id_rt=7=idex_reg_dest, id_uses_rt=1 -> 3 consecutive bubble cycles then RUN; with id_uses_rt=0 -> no stall. With idex_reg_dest=0 -> no stall.
- Simultaneous ex_jump=1 and hz=1 -> squash only: ifid_flush=idex_flush=1, all enables 1, flush_count=1.
- mem_busy high for 4 cycles during the second bubble of LOAD_BUBBLES=3 -> 4 freeze cycles, then exactly 2 more bubbles; stall_cycles=7 (1+4+2).
- MEM_TIMEOUT=3, mem_busy high for 5 cycles -> mem_timeout=1 after the 3rd cycle and stays 1 after mem_busy drops; cleared only by reset.
- Reset asserted in LOAD_STALL -> that cycle outputs enables 0 and flushes 1; next cycle RUN with all counters 0.
